can_host_sched: RTL and testbench

- Parametrised host-side traffic scheduler for a multi-node CAN cluster. Replaces ad-hoc stimulus loops.
- Each node gets its own transmit mailbox FIFO. The block serves each node's data_in_req load handshake from that FIFO.
- On Retransmit it replays the in-flight frame, bounded by a retry limit, with optional priority boost.
- It collects received frames from all nodes into one tagged RX FIFO and keeps transaction statistics counters.

---
 rtl/can_host_sched_pkg.sv | 18 +
 rtl/can_sync_fifo.sv | 43 ++++
 rtl/can_host_sched.sv | 215 +++++++++++++++++++++
 tb/tb_can_host_sched.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_host_sched_pkg.sv
// Shared frame type, ID constants and channel states for the CAN host scheduler.
package can_host_sched_pkg;

  localparam int DATA_SIZE = 64;
  localparam int ID_SIZE   = 11;

  localparam logic [ID_SIZE-1:0] ID_IDLE  = 11'h7FF;
  localparam logic [ID_SIZE-1:0] ID_BOOST = 11'h000;

  typedef struct packed {
    logic [DATA_SIZE-1:0] data;
    logic [ID_SIZE-1:0]   tx_id;
    logic [ID_SIZE-1:0]   rx_id;
  } can_frame_t;

  typedef enum logic [1:0] {IDLE, INFLIGHT, RETRY} tx_state_e;

endpackage

// File: rtl/can_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; pushes while full and pops while empty are ignored.
module can_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // NOTE: storage has no reset; occupancy is defined purely by the pointers.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/can_host_sched.sv
// Host-side CAN traffic scheduler: per-node TX mailboxes with retry/replay,
// a shared round-robin RX collector and saturating statistics counters.
module can_host_sched
  import can_host_sched_pkg::*;
#(
  parameter int NODES       = 4,
  parameter int TX_DEPTH    = 8,
  parameter int RX_DEPTH    = 16,
  parameter int MAX_RETRY   = 3,
  parameter bit RETRY_BOOST = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                wr_valid,
  input  logic [$clog2(NODES)-1:0]            wr_node,
  input  can_frame_t                          wr_frame,
  output logic                                wr_ready,
  input  logic [NODES-1:0]                    data_in_req,
  input  logic [NODES-1:0]                    Retransmit,
  input  logic [NODES-1:0]                    data_out_req,
  input  logic [NODES-1:0][DATA_SIZE-1:0]     Rx_packet,
  output logic [NODES-1:0][DATA_SIZE-1:0]     In_packet,
  output logic [NODES-1:0][ID_SIZE-1:0]       Tx_ID,
  output logic [NODES-1:0][ID_SIZE-1:0]       Rx_ID,
  input  logic                                rd_ready,
  output logic                                rd_valid,
  output logic [$clog2(NODES)-1:0]            rd_node,
  output logic [DATA_SIZE-1:0]                rd_data,
  output logic [CNT_W-1:0]                    cnt_attempt,
  output logic [CNT_W-1:0]                    cnt_success,
  output logic [CNT_W-1:0]                    cnt_retry,
  output logic [CNT_W-1:0]                    cnt_drop,
  output logic [CNT_W-1:0]                    cnt_rx_ovf
);

  localparam int NODE_W = $clog2(NODES);
  localparam int RW     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int FW     = $bits(can_frame_t);
  localparam int RXW    = NODE_W + DATA_SIZE;

  logic [NODES-1:0] tx_full, tx_empty, tx_pop, tx_push;
  can_frame_t       tx_head [NODES];
  logic [NODES-1:0] ev_attempt, ev_success, ev_retry, ev_drop, ev_ovf;

  assign wr_ready = !tx_full[wr_node];

  for (genvar g = 0; g < NODES; g++) begin : g_tx
    tx_state_e            state_q, state_d, eff;
    logic [RW-1:0]        rcnt_q, rcnt_d;
    can_frame_t           fl_q, fl_d;
    logic [DATA_SIZE-1:0] pkt_q, pkt_d;
    logic [ID_SIZE-1:0]   txid_q, txid_d, rxid_q, rxid_d;
    logic                 pop, att, suc, rty, drp, issue_new;

    assign tx_push[g] = wr_valid && wr_ready && (wr_node == NODE_W'(g));

    can_sync_fifo #(.WIDTH(FW), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clock (clock),        .reset (reset),
      .push  (tx_push[g]),   .pop   (tx_pop[g]),
      .din   (wr_frame),     .dout  (tx_head[g]),
      .full  (tx_full[g]),   .empty (tx_empty[g])
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
      eff = state_q;  state_d = state_q;  rcnt_d = rcnt_q;  fl_d = fl_q;
      pkt_d = pkt_q;  txid_d = txid_q;    rxid_d = rxid_q;
      pop = 1'b0;  att = 1'b0;  suc = 1'b0;  rty = 1'b0;  drp = 1'b0;  issue_new = 1'b0;
      // A retransmit is applied before a same-cycle request, so that request replays.
      if (state_q == INFLIGHT && Retransmit[g]) eff = RETRY;
      state_d = eff;
      if (data_in_req[g]) begin
        unique case (eff)
          RETRY: begin
            if (rcnt_q < RW'(MAX_RETRY)) begin
              pkt_d   = fl_q.data;
              txid_d  = RETRY_BOOST ? ID_BOOST : fl_q.tx_id;
              rxid_d  = fl_q.rx_id;
              rcnt_d  = rcnt_q + RW'(1);
              rty     = 1'b1;
              state_d = INFLIGHT;
            end else begin
              drp       = 1'b1;
              rcnt_d    = '0;
              issue_new = 1'b1;
            end
          end
          INFLIGHT: begin
            suc       = 1'b1;
            issue_new = 1'b1;
          end
          default: issue_new = 1'b1;
        endcase
        if (issue_new) begin
          if (!tx_empty[g]) begin
            pop     = 1'b1;
            att     = 1'b1;
            fl_d    = tx_head[g];
            pkt_d   = tx_head[g].data;
            txid_d  = tx_head[g].tx_id;
            rxid_d  = tx_head[g].rx_id;
            rcnt_d  = '0;
            state_d = INFLIGHT;
          end else begin
            pkt_d   = '0;
            txid_d  = ID_IDLE;
            state_d = IDLE;
          end
        end
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;  rcnt_q <= '0;  fl_q <= '0;
        pkt_q <= '0;  txid_q <= ID_IDLE;  rxid_q <= '0;
      end else begin
        state_q <= state_d;  rcnt_q <= rcnt_d;  fl_q <= fl_d;
        pkt_q <= pkt_d;  txid_q <= txid_d;  rxid_q <= rxid_d;
      end
    end

    assign tx_pop[g]     = pop;
    assign ev_attempt[g] = att;
    assign ev_success[g] = suc;
    assign ev_retry[g]   = rty;
    assign ev_drop[g]    = drp;
    assign In_packet[g]  = pkt_q;
    assign Tx_ID[g]      = txid_q;
    assign Rx_ID[g]      = rxid_q;
  end

  // RX capture registers drained round-robin into the shared tagged FIFO.
  logic [NODES-1:0]                pending, pend_d, cap, drained;
  logic [NODES-1:0][DATA_SIZE-1:0] cap_data;
  logic [NODE_W-1:0]               last_q, gnt_idx, cand;
  logic                            gnt_valid, drain, rx_full, rx_empty;
  logic [RXW-1:0]                  rx_dout;
  int                              idx;

  always_comb begin
    gnt_valid = 1'b0;  gnt_idx = '0;  idx = 0;  cand = '0;
    for (int j = 1; j <= NODES; j++) begin
      idx  = (int'(last_q) + j) % NODES;
      cand = NODE_W'(idx);
      if (!gnt_valid && pending[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign drain   = gnt_valid && !rx_full;
  assign drained = drain ? (NODES'(1) << gnt_idx) : '0;

  always_comb begin
    cap = '0;  ev_ovf = '0;  pend_d = '0;
    for (int i = 0; i < NODES; i++) begin
      cap[i]    = data_out_req[i] && (!pending[i] || drained[i]);
      ev_ovf[i] = data_out_req[i] && pending[i] && !drained[i];
      pend_d[i] = cap[i] || (pending[i] && !drained[i]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
      last_q  <= NODE_W'(NODES - 1);
    end else begin
      pending <= pend_d;
      if (drain) last_q <= gnt_idx;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NODES; i++) begin
      if (cap[i]) cap_data[i] <= Rx_packet[i];
    end
  end

  can_sync_fifo #(.WIDTH(RXW), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clock (clock),                  .reset (reset),
    .push  (drain),                  .pop   (rd_valid && rd_ready),
    .din   ({gnt_idx, cap_data[gnt_idx]}), .dout (rx_dout),
    .full  (rx_full),                .empty (rx_empty)
  );

  assign rd_valid = !rx_empty;
  assign rd_node  = rx_dout[RXW-1:DATA_SIZE];
  assign rd_data  = rx_dout[DATA_SIZE-1:0];

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [NODES-1:0] ev);
    logic [CNT_W-1:0] s;
    s = c;
    for (int i = 0; i < NODES; i++) begin
      if (ev[i] && (s != '1)) s = s + CNT_W'(1);
    end
    return s;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_attempt <= '0;  cnt_success <= '0;  cnt_retry <= '0;
      cnt_drop    <= '0;  cnt_rx_ovf  <= '0;
    end else begin
      cnt_attempt <= sat_add(cnt_attempt, ev_attempt);
      cnt_success <= sat_add(cnt_success, ev_success);
      cnt_retry   <= sat_add(cnt_retry,   ev_retry);
      cnt_drop    <= sat_add(cnt_drop,    ev_drop);
      cnt_rx_ovf  <= sat_add(cnt_rx_ovf,  ev_ovf);
    end
  end

endmodule

// File: tb/tb_can_host_sched.sv
// Self-checking bench for can_host_sched: a queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_can_host_sched;
  import can_host_sched_pkg::*;

  localparam int NODES = 4, TX_DEPTH = 8, RX_DEPTH = 16, MAX_RETRY = 3, CNT_W = 16;
  localparam bit RETRY_BOOST = 1'b1;
  localparam int NODE_W = $clog2(NODES);

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic wr_valid = 1'b0;
  logic [NODE_W-1:0] wr_node = '0;
  can_frame_t wr_frame = '0;
  logic wr_ready;
  logic [NODES-1:0] data_in_req = '0, Retransmit = '0, data_out_req = '0;
  logic [NODES-1:0][DATA_SIZE-1:0] Rx_packet = '0;
  logic [NODES-1:0][DATA_SIZE-1:0] In_packet;
  logic [NODES-1:0][ID_SIZE-1:0] Tx_ID, Rx_ID;
  logic rd_ready = 1'b0;
  logic rd_valid;
  logic [NODE_W-1:0] rd_node;
  logic [DATA_SIZE-1:0] rd_data;
  logic [CNT_W-1:0] cnt_attempt, cnt_success, cnt_retry, cnt_drop, cnt_rx_ovf;

  can_host_sched #(
    .NODES(NODES), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH),
    .MAX_RETRY(MAX_RETRY), .RETRY_BOOST(RETRY_BOOST), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_node(wr_node),
    .wr_frame(wr_frame), .wr_ready(wr_ready), .data_in_req(data_in_req),
    .Retransmit(Retransmit), .data_out_req(data_out_req), .Rx_packet(Rx_packet),
    .In_packet(In_packet), .Tx_ID(Tx_ID), .Rx_ID(Rx_ID), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_node(rd_node), .rd_data(rd_data),
    .cnt_attempt(cnt_attempt), .cnt_success(cnt_success), .cnt_retry(cnt_retry),
    .cnt_drop(cnt_drop), .cnt_rx_ovf(cnt_rx_ovf)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  can_frame_t txq [NODES][$];
  can_frame_t m_frame [NODES];
  bit m_busy [NODES], m_retx [NODES];
  int m_replays [NODES];
  logic [63:0] m_pkt [NODES];
  logic [10:0] m_tx [NODES], m_rx [NODES];
  int m_attempt, m_success, m_retry, m_drop, m_ovf;
  bit m_pend [NODES];
  logic [63:0] m_cap [NODES];
  int m_last;
  int rxq_node [$];
  logic [63:0] rxq_data [$];

  function automatic logic [CNT_W-1:0] sat(input int v);
    return (v > (2**CNT_W - 1)) ? '1 : CNT_W'(v);
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NODES; n++) begin
      txq[n].delete();
      m_busy[n] = 0;  m_retx[n] = 0;  m_replays[n] = 0;
      m_pkt[n] = '0;  m_tx[n] = 11'h7FF;  m_rx[n] = '0;  m_pend[n] = 0;
    end
    m_attempt = 0;  m_success = 0;  m_retry = 0;  m_drop = 0;  m_ovf = 0;
    m_last = NODES - 1;
    rxq_node.delete();  rxq_data.delete();
  endtask

  task automatic model_step();
    bit push_ok, full_pre;
    push_ok = wr_valid && (txq[wr_node].size() < TX_DEPTH);
    for (int n = 0; n < NODES; n++) begin
      if (m_busy[n] && Retransmit[n]) m_retx[n] = 1;
      if (data_in_req[n]) begin
        if (m_busy[n] && m_retx[n] && m_replays[n] < MAX_RETRY) begin
          m_pkt[n] = m_frame[n].data;
          m_tx[n]  = RETRY_BOOST ? 11'h000 : m_frame[n].tx_id;
          m_rx[n]  = m_frame[n].rx_id;
          m_replays[n]++;  m_retry++;  m_retx[n] = 0;
        end else begin
          if (m_busy[n] && m_retx[n]) m_drop++;
          else if (m_busy[n]) m_success++;
          if (txq[n].size() > 0) begin
            m_frame[n] = txq[n].pop_front();
            m_pkt[n] = m_frame[n].data;  m_tx[n] = m_frame[n].tx_id;  m_rx[n] = m_frame[n].rx_id;
            m_attempt++;  m_busy[n] = 1;  m_replays[n] = 0;
          end else begin
            m_pkt[n] = '0;  m_tx[n] = 11'h7FF;  m_busy[n] = 0;
          end
          m_retx[n] = 0;
        end
      end
    end
    if (push_ok) txq[wr_node].push_back(wr_frame);
    full_pre = rxq_node.size() >= RX_DEPTH;
    if (rxq_node.size() > 0 && rd_ready) begin
      void'(rxq_node.pop_front());
      void'(rxq_data.pop_front());
    end
    if (!full_pre) begin
      for (int k = 1; k <= NODES; k++) begin
        int n;
        n = (m_last + k) % NODES;
        if (m_pend[n]) begin
          rxq_node.push_back(n);  rxq_data.push_back(m_cap[n]);
          m_pend[n] = 0;  m_last = n;
          break;
        end
      end
    end
    for (int n = 0; n < NODES; n++) begin
      if (data_out_req[n]) begin
        if (m_pend[n]) m_ovf++;
        else begin
          m_cap[n] = Rx_packet[n];  m_pend[n] = 1;
        end
      end
    end
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    for (int n = 0; n < NODES; n++) begin
      check($sformatf("In_packet[%0d]", n), In_packet[n], m_pkt[n]);
      check($sformatf("Tx_ID[%0d]", n), 64'(Tx_ID[n]), 64'(m_tx[n]));
      check($sformatf("Rx_ID[%0d]", n), 64'(Rx_ID[n]), 64'(m_rx[n]));
    end
    check("wr_ready", 64'(wr_ready), 64'(txq[wr_node].size() < TX_DEPTH));
    check("rd_valid", 64'(rd_valid), 64'(rxq_node.size() > 0));
    if (rxq_node.size() > 0) begin
      check("rd_node", 64'(rd_node), 64'(rxq_node[0]));
      check("rd_data", rd_data, rxq_data[0]);
    end
    check("cnt_attempt", 64'(cnt_attempt), 64'(sat(m_attempt)));
    check("cnt_success", 64'(cnt_success), 64'(sat(m_success)));
    check("cnt_retry",   64'(cnt_retry),   64'(sat(m_retry)));
    check("cnt_drop",    64'(cnt_drop),    64'(sat(m_drop)));
    check("cnt_rx_ovf",  64'(cnt_rx_ovf),  64'(sat(m_ovf)));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic push_frame(input int n, input logic [63:0] d, input logic [10:0] tid, input logic [10:0] rid);
    wr_valid = 1'b1;  wr_node = NODE_W'(n);
    wr_frame.data = d;  wr_frame.tx_id = tid;  wr_frame.rx_id = rid;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic req(input int n);
    data_in_req = NODES'(1) << n;  tick();  data_in_req = '0;
  endtask

  task automatic retx(input int n);
    Retransmit = NODES'(1) << n;  tick();  Retransmit = '0;
  endtask

  initial begin
    repeat (3) tick();
    check("rst_Tx_ID0", 64'(Tx_ID[0]), 64'h7FF);
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_cnt_attempt", 64'(cnt_attempt), 64'd0);
    reset = 1'b0;
    tick();

    // Basic issue, then success on an empty-FIFO request.
    push_frame(0, 64'hFFFFEEEE0000FEF1, 11'h001, 11'h005);
    req(0);
    check("basic_In_packet0", In_packet[0], 64'hFFFFEEEE0000FEF1);
    check("basic_Tx_ID0", 64'(Tx_ID[0]), 64'h001);
    check("basic_cnt_attempt", 64'(cnt_attempt), 64'd1);
    check("model_attempt", 64'(m_attempt), 64'd1);
    req(0);
    check("filler_cnt_success", 64'(cnt_success), 64'd1);
    check("filler_Tx_ID0", 64'(Tx_ID[0]), 64'h7FF);
    check("filler_In_packet0", In_packet[0], 64'd0);
    check("filler_Rx_ID0", 64'(Rx_ID[0]), 64'h005);

    // Replay with boost.
    push_frame(1, 64'h1234, 11'h7FF, 11'h00A);
    req(1);
    retx(1);
    req(1);
    check("replay_In_packet1", In_packet[1], 64'h1234);
    check("replay_Tx_ID1", 64'(Tx_ID[1]), 64'h000);
    check("replay_Rx_ID1", 64'(Rx_ID[1]), 64'h00A);
    check("replay_cnt_retry", 64'(cnt_retry), 64'd1);

    // Retry limit: pair 1 is same-cycle, pairs 2..4 are back-to-back.
    push_frame(1, 64'hAAAA, 11'h010, 11'h011);
    push_frame(1, 64'hBBBB, 11'h020, 11'h021);
    req(1);
    check("limit_Tx_ID1_A", 64'(Tx_ID[1]), 64'h010);
    Retransmit = 4'b0010;  data_in_req = 4'b0010;  tick();
    Retransmit = '0;  data_in_req = '0;
    check("same_cycle_Tx_ID1", 64'(Tx_ID[1]), 64'h000);
    check("same_cycle_In_packet1", In_packet[1], 64'hAAAA);
    for (int p = 0; p < 3; p++) begin
      retx(1);
      req(1);
    end
    check("limit_cnt_retry", 64'(cnt_retry), 64'd4);
    check("limit_cnt_drop", 64'(cnt_drop), 64'd1);
    check("limit_cnt_attempt", 64'(cnt_attempt), 64'd4);
    check("limit_In_packet1", In_packet[1], 64'hBBBB);
    check("limit_Tx_ID1_B", 64'(Tx_ID[1]), 64'h020);
    check("model_drop", 64'(m_drop), 64'd1);

    // Fill node 2 past its depth, then drain in order.
    for (int k = 0; k < 8; k++) push_frame(2, 64'h200 + 64'(k), 11'(k + 1), 11'h030 + 11'(k));
    check("full_wr_ready", 64'(wr_ready), 64'd0);
    push_frame(2, 64'h999, 11'h099, 11'h099);
    for (int k = 0; k < 8; k++) begin
      req(2);
      check($sformatf("order_In_packet2_%0d", k), In_packet[2], 64'h200 + 64'(k));
      check($sformatf("order_Tx_ID2_%0d", k), 64'(Tx_ID[2]), 64'(k + 1));
    end
    check("order_cnt_attempt", 64'(cnt_attempt), 64'd12);
    check("order_wr_ready", 64'(wr_ready), 64'd1);
    req(2);
    check("order_tail_Tx_ID2", 64'(Tx_ID[2]), 64'h7FF);
    check("order_tail_In_packet2", In_packet[2], 64'd0);
    check("order_cnt_success", 64'(cnt_success), 64'd10);

    // RX round-robin collection with an overflow on node 3.
    rd_ready = 1'b1;
    for (int n = 0; n < NODES; n++) Rx_packet[n] = 64'hC0 + 64'(n);
    data_out_req = 4'hF;  tick();
    check("rx_empty_first", 64'(rd_valid), 64'd0);
    Rx_packet[3] = 64'hDD;
    data_out_req = 4'b1000;  tick();
    data_out_req = '0;
    for (int n = 0; n < NODES; n++) begin
      check($sformatf("rx_rd_node_%0d", n), 64'(rd_node), 64'(n));
      check($sformatf("rx_rd_data_%0d", n), rd_data, 64'hC0 + 64'(n));
      tick();
    end
    check("rx_drained", 64'(rd_valid), 64'd0);
    check("rx_cnt_ovf", 64'(cnt_rx_ovf), 64'd1);

    // RX FIFO full: drain stalls, pending entries survive, later captures overflow.
    rd_ready = 1'b0;
    for (int r = 1; r <= 6; r++) begin
      for (int n = 0; n < NODES; n++) Rx_packet[n] = 64'h1000 * 64'(r) + 64'(n);
      data_out_req = 4'hF;  tick();
      data_out_req = '0;
      repeat (4) tick();
    end
    check("stall_cnt_ovf", 64'(cnt_rx_ovf), 64'd5);
    check("stall_rd_node", 64'(rd_node), 64'd0);
    check("stall_rd_data", rd_data, 64'h1000);
    rd_ready = 1'b1;
    repeat (30) tick();
    check("stall_drained", 64'(rd_valid), 64'd0);
    rd_ready = 1'b0;

    // Reset in the middle of an in-flight frame with non-empty FIFOs.
    push_frame(0, 64'hE0, 11'h0E0, 11'h0E1);
    push_frame(0, 64'hE1, 11'h0E2, 11'h0E3);
    push_frame(3, 64'hF3, 11'h0F3, 11'h0F4);
    req(0);
    check("pre_rst_In_packet0", In_packet[0], 64'hE0);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_In_packet0", In_packet[0], 64'd0);
    check("rst_mid_Tx_ID0", 64'(Tx_ID[0]), 64'h7FF);
    check("rst_mid_Rx_ID0", 64'(Rx_ID[0]), 64'd0);
    check("rst_mid_cnt_attempt", 64'(cnt_attempt), 64'd0);
    check("rst_mid_cnt_ovf", 64'(cnt_rx_ovf), 64'd0);
    check("rst_mid_wr_ready", 64'(wr_ready), 64'd1);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    data_in_req = 4'b1001;  tick();  data_in_req = '0;
    check("post_rst_Tx_ID0", 64'(Tx_ID[0]), 64'h7FF);
    check("post_rst_Tx_ID3", 64'(Tx_ID[3]), 64'h7FF);
    check("post_rst_In_packet0", In_packet[0], 64'd0);
    check("post_rst_cnt_attempt", 64'(cnt_attempt), 64'd0);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
